// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Sequential restoring divider for DIV (signed) and DIVU (unsigned).
// One quotient bit is retired per cycle. The quotient is returned on LO and the
// remainder on HI. The handshake matches the Booth multiplier: the request is
// held high as a level, and the pipeline stalls until result_ready.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   div_en       in   1   request level, held high until the result is consumed
//   div_signed   in   1   1 = DIV (two's complement), 0 = DIVU
//   data_a       in   DW  dividend, sampled only on accept
//   data_b       in   DW  divisor, sampled only on accept
//   hilo_select  in   1   0 = quotient (LO), 1 = remainder (HI)
//   busy         out  1   iterating or applying sign fix-up
//   result_ready out  1   result valid (DONE)
//   div_by_zero  out  1   in DONE, the accepted divisor was zero
//   div_result   out  DW  selected result while result_ready, else zero
// -----------------------------------------------------------------------------
module div_unit #(
    parameter int DW = 32,
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          div_en,
    input  logic          div_signed,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    input  logic          hilo_select,
    output logic          busy,
    output logic          result_ready,
    output logic          div_by_zero,
    output logic [DW-1:0] div_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvs_q, dvs_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;
    logic          dbz_q, dbz_d;

    logic          a_neg_s;
    logic          b_neg_s;
    logic [DW-1:0] abs_a_s;
    logic [DW-1:0] abs_b_s;
    logic [DW:0]   sh_s;
    logic [DW:0]   diff_s;

    // Operand magnitudes; the most negative value maps to 2^(DW-1) unsigned.
    assign a_neg_s = div_signed & data_a[DW-1];
    assign b_neg_s = div_signed & data_b[DW-1];
    assign abs_a_s = a_neg_s ? ({DW{1'b0}} - data_a) : data_a;
    assign abs_b_s = b_neg_s ? ({DW{1'b0}} - data_b) : data_b;

    // Trial subtraction one bit wider than the operands; the top bit is the borrow.
    assign sh_s   = {rem_q, quo_q[DW-1]};
    assign diff_s = sh_s - {1'b0, dvs_q};

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (div_en) begin
                    if (data_b == {DW{1'b0}}) begin
                        // Divide by zero bypasses the iteration entirely.
                        quo_d   = {DW{1'b1}};
                        rem_d   = data_a;
                        dvs_d   = {DW{1'b0}};
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = abs_a_s;
                        rem_d   = {DW{1'b0}};
                        dvs_d   = abs_b_s;
                        q_neg_d = a_neg_s ^ b_neg_s;
                        r_neg_d = a_neg_s;
                        dbz_d   = 1'b0;
                        cnt_d   = {CW{1'b0}};
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (!div_en) begin
                    state_d = IDLE;
                end else begin
                    if (diff_s[DW] == 1'b0) begin
                        rem_d = diff_s[DW-1:0];
                        quo_d = {quo_q[DW-2:0], 1'b1};
                    end else begin
                        rem_d = sh_s[DW-1:0];
                        quo_d = {quo_q[DW-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == CW'(DW-1)) begin
                        state_d = FIX;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            FIX: begin
                if (!div_en) begin
                    state_d = IDLE;
                end else begin
                    quo_d   = q_neg_q ? ({DW{1'b0}} - quo_q) : quo_q;
                    rem_d   = r_neg_q ? ({DW{1'b0}} - rem_q) : rem_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!div_en) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
            quo_q   <= {DW{1'b0}};
            rem_q   <= {DW{1'b0}};
            dvs_q   <= {DW{1'b0}};
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dbz_q   <= dbz_d;
        end
    end

    // Status flags decode straight from the state register.
    assign busy         = (state_q == CALC) || (state_q == FIX);
    assign result_ready = (state_q == DONE);
    assign div_by_zero  = (state_q == DONE) && dbz_q;
    assign div_result   = result_ready ? (hilo_select ? rem_q : quo_q) : {DW{1'b0}};

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_en;
    logic        div_signed;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        hilo_select;
    logic        busy;
    logic        result_ready;
    logic        div_by_zero;
    logic [31:0] div_result;

    int checks;
    int failures;

    div_unit #(.DW(32), .CW(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_en       (div_en),
        .div_signed   (div_signed),
        .data_a       (data_a),
        .data_b       (data_b),
        .hilo_select  (hilo_select),
        .busy         (busy),
        .result_ready (result_ready),
        .div_by_zero  (div_by_zero),
        .div_result   (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Run one operation to completion, then release div_en and leave one idle cycle.
    task automatic run_op(input string tag, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input int exp_lat,
                          input logic exp_dbz, output int busy_n);
        int lat;
        int leak;
        @(negedge clk);
        div_en      = 1'b1;
        div_signed  = sg;
        data_a      = a;
        data_b      = b;
        hilo_select = 1'b0;
        lat    = 0;
        leak   = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                data_a = ~a;
                data_b = b + 32'd3;
            end
            if (busy) busy_n++;
            if (!result_ready && div_result != 32'd0) leak++;
        end while (!result_ready && lat < 100);
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " result_zero_before_done"}, 32'(leak), 32'd0);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
        chk({tag, " quotient"}, div_result, exp_q);
        hilo_select = 1'b1;
        #1;
        chk({tag, " remainder"}, div_result, exp_r);
        @(negedge clk);
        chk({tag, " held_remainder"}, div_result, exp_r);
        div_en = 1'b0;
        @(negedge clk);
        chk({tag, " ready_drop"}, {31'd0, result_ready}, 32'd0);
        chk({tag, " result_zero_idle"}, div_result, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int bn;
        int rr_seen;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        div_en      = 1'b0;
        div_signed  = 1'b0;
        data_a      = 32'd0;
        data_b      = 32'd0;
        hilo_select = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset ready", {31'd0, result_ready}, 32'd0);
        chk("reset dbz", {31'd0, div_by_zero}, 32'd0);
        chk("reset result", div_result, 32'd0);
        rst = 1'b0;

        // Basic unsigned, with latency and busy-length checks
        run_op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0, bn);
        chk("divu_100_7 busy_cycles", 32'(bn), 32'd33);

        // Signed sign rules
        run_op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, 1'b0, bn);
        run_op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 34, 1'b0, bn);
        run_op("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 34, 1'b0, bn);

        // Boundaries
        run_op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 34, 1'b0, bn);
        run_op("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 34, 1'b0, bn);

        // Divide by zero, then a normal op must clear the flag
        run_op("divu_dbz", 1'b0, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1, 1'b1, bn);
        chk("divu_dbz busy_cycles", 32'(bn), 32'd0);
        run_op("divu_after_dbz", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 34, 1'b0, bn);

        // Reset in the middle of the iteration
        @(negedge clk);
        div_en     = 1'b1;
        div_signed = 1'b0;
        data_a     = 32'd100;
        data_b     = 32'd7;
        repeat (11) @(negedge clk);
        chk("mid_calc busy", {31'd0, busy}, 32'd1);
        rst    = 1'b1;
        div_en = 1'b0;
        @(negedge clk);
        chk("mid_rst busy", {31'd0, busy}, 32'd0);
        chk("mid_rst ready", {31'd0, result_ready}, 32'd0);
        chk("mid_rst dbz", {31'd0, div_by_zero}, 32'd0);
        chk("mid_rst result", div_result, 32'd0);
        rst = 1'b0;
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 1'b0, bn);

        // Abort by dropping div_en during the iteration
        @(negedge clk);
        div_en     = 1'b1;
        div_signed = 1'b0;
        data_a     = 32'd100;
        data_b     = 32'd7;
        repeat (6) @(negedge clk);
        div_en  = 1'b0;
        rr_seen = 0;
        @(negedge clk);
        chk("abort busy", {31'd0, busy}, 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (result_ready) rr_seen++;
        end
        chk("abort ready_never", 32'(rr_seen), 32'd0);
        chk("abort result", div_result, 32'd0);
        run_op("divu_1000_10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 1'b0, bn);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
